data_mem_lsu: RTL and testbench

Load/store unit and data memory for the single-cycle RISC-V core, directly downstream of the ALU. It consumes `ALUResult` as a byte address and the rs2 value as store data, and returns load data to the write-back mux. It performs byte-lane store masking, load sign or zero extension, and alignment and range checking with a sticky fault record. Optional memory-mapped registers provide a cycle counter and an output port.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/dmem_ram.sv | 27 ++
 rtl/data_mem_lsu.sv | 157 +++++++++++++++
 tb/tb_data_mem_lsu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and load-extension helper for the data-memory LSU.
// MMIO register map is only decoded when LSU_MMIO_EN is defined.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam logic [31:0] OFF_CNT   = 32'h0000_0000;
  localparam logic [31:0] OFF_OUT   = 32'h0000_0004;
  localparam logic [31:0] OFF_STAT  = 32'h0000_0008;

  function automatic logic [31:0] lsu_extend(
    input logic [31:0] word,
    input logic [1:0]  addr_lo,
    input logic [2:0]  funct3
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    unique case (funct3)
      F3_B:    lsu_extend = {{24{b[7]}}, b};
      F3_BU:   lsu_extend = {24'b0, b};
      F3_H:    lsu_extend = {{16{h[15]}}, h};
      F3_HU:   lsu_extend = {16'b0, h};
      default: lsu_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-enable data RAM: asynchronous read, synchronous write.
// Contents undefined until written.
module dmem_ram #(
  parameter int    WORDS     = 256,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(WORDS)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [WORDS];

  assign rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit with data RAM, fault capture and optional MMIO.
// Define LSU_MMIO_EN to add cycle counter, output port and status regs.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int    MEM_WORDS = 256,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        misaligned,
  output logic        fault_sticky,
  output logic [31:0] fault_addr,
  output logic [31:0] mmio_out
);

  localparam int AW = $clog2(MEM_WORDS);

  logic        active;
  logic        store;
  logic        f3_ok;
  logic        in_ram;
  logic        mmio_ok;
  logic        fault;
  logic        ram_we;
  logic        stat_clr;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] ram_q;
  logic [31:0] mmio_rd;

  // classify the access and detect faults
  always_comb begin
    active = MemRead | MemWrite;
    store  = MemWrite;
    f3_ok  = 1'b0;
    unique case (funct3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = ~store;
      default:          f3_ok = 1'b0;
    endcase
    misaligned = active &
      (((funct3[1:0] == 2'b01) & ALUResult[0]) |
       ((funct3 == F3_W) & (ALUResult[1:0] != 2'b00)));
    in_ram = ~ALUResult[31] &
      ((ALUResult >> (AW + 2)) == 32'd0);
    fault = active & (misaligned | ~f3_ok |
      (ALUResult[31] ? ~mmio_ok : ~in_ram));
  end

  // replicate store data and pick byte lanes
  always_comb begin
    be    = 4'b0000;
    wword = WriteData;
    unique case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << ALUResult[1:0];
        wword = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be    = ALUResult[1] ? 4'b1100 : 4'b0011;
        wword = {2{WriteData[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign ram_we = active & store & ~fault & ~reset & in_ram;

  dmem_ram #(
    .WORDS     (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (be),
    .idx   (ALUResult[AW+1:2]),
    .wdata (wword),
    .rdata (ram_q)
  );

  // load data; zero when idle or faulting
  always_comb begin
    ReadData = '0;
    if (active & ~fault) begin
      ReadData = ALUResult[31] ? mmio_rd :
        lsu_extend(ram_q, ALUResult[1:0], funct3);
    end
  end

`ifdef LSU_MMIO_EN
  logic [31:0] cnt;
  logic [31:0] out_q;
  logic        hit_cnt;
  logic        hit_out;
  logic        hit_stat;

  // MMIO register decode and read mux
  always_comb begin
    hit_cnt  = ALUResult == (MMIO_BASE + OFF_CNT);
    hit_out  = ALUResult == (MMIO_BASE + OFF_OUT);
    hit_stat = ALUResult == (MMIO_BASE + OFF_STAT);
    mmio_ok  = (funct3 == F3_W) &
      ((hit_cnt & ~store) | hit_out | hit_stat);
    mmio_rd  = '0;
    unique case (1'b1)
      hit_cnt:  mmio_rd = cnt;
      hit_out:  mmio_rd = out_q;
      hit_stat: mmio_rd = {31'b0, fault_sticky};
      default:  mmio_rd = '0;
    endcase
  end

  assign stat_clr = active & store & ~fault &
    hit_stat & WriteData[0];

  // free-running cycle counter and output port
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      out_q <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      if (active & store & ~fault & hit_out) out_q <= WriteData;
    end
  end

  assign mmio_out = out_q;
`else
  assign mmio_ok  = 1'b0;
  assign mmio_rd  = '0;
  assign stat_clr = 1'b0;
  assign mmio_out = '0;
`endif

  // first-fault capture, cleared by reset or status write
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_sticky <= 1'b0;
      fault_addr   <= '0;
    end else if (stat_clr) begin
      fault_sticky <= 1'b0;
      fault_addr   <= '0;
    end else if (fault & ~fault_sticky) begin
      fault_sticky <= 1'b1;
      fault_addr   <= ALUResult;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomised bench for data_mem_lsu against a byte-array model.
// Follows LSU_MMIO_EN the same way as the design build.
module tb_data_mem_lsu;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        misaligned;
  logic        fault_sticky;
  logic [31:0] fault_addr;
  logic [31:0] mmio_out;

  always #5 clk = ~clk;

  data_mem_lsu #(
    .MEM_WORDS (256),
    .INIT_FILE ("")
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .funct3       (funct3),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .misaligned   (misaligned),
    .fault_sticky (fault_sticky),
    .fault_addr   (fault_addr),
    .mmio_out     (mmio_out)
  );

  int vecs = 0;
  int errs = 0;

  logic [7:0]  mm [1024];
  logic        m_sticky = 1'b0;
  logic [31:0] m_faddr = '0;
  logic [31:0] m_out = '0;
  logic [31:0] m_cnt = '0;
  logic [31:0] rd_obs;
  logic        mis_obs;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic void model_eval(
    input  logic        w,
    input  logic        r,
    input  logic [2:0]  f,
    input  logic [31:0] a,
    output logic        flt,
    output logic        mis,
    output logic [31:0] rd
  );
    logic        act;
    logic        ok;
    int unsigned sz;
    int          i;
    act = w | r;
    sz  = acc_size(f);
    mis = act && sz > 1 && (a % sz) != 0;
`ifdef LSU_MMIO_EN
    ok = (f == 3'd2) &&
         ((a == BASE && !w) || a == BASE + 4 || a == BASE + 8);
`else
    ok = 1'b0;
`endif
    flt = act && (mis || sz == 0 || (w && f[2]) ||
                  (a[31] ? !ok : a >= 32'd1024));
    rd = '0;
    if (act && !flt) begin
      if (a[31]) begin
        if (a == BASE)          rd = m_cnt;
        else if (a == BASE + 4) rd = m_out;
        else                    rd = {31'b0, m_sticky};
      end else begin
        i = int'(a);
        case (f)
          3'd0: rd = {{24{mm[i][7]}}, mm[i]};
          3'd4: rd = {24'b0, mm[i]};
          3'd1: rd = {{16{mm[i+1][7]}}, mm[i+1], mm[i]};
          3'd5: rd = {16'b0, mm[i+1], mm[i]};
          default: rd = {mm[i+3], mm[i+2], mm[i+1], mm[i]};
        endcase
      end
    end
  endfunction

  task automatic model_commit(input logic rs, input logic w,
                              input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] d, input logic flt);
    int i;
    if (rs) begin
      m_sticky = 1'b0;
      m_faddr  = '0;
      m_out    = '0;
      m_cnt    = '0;
    end else begin
      m_cnt = m_cnt + 1;
      if (flt && !m_sticky) begin
        m_sticky = 1'b1;
        m_faddr  = a;
      end else if (w && !flt) begin
        if (!a[31]) begin
          i = int'(a);
          mm[i] = d[7:0];
          if (acc_size(f) >= 2) mm[i+1] = d[15:8];
          if (acc_size(f) == 4) begin
            mm[i+2] = d[23:16];
            mm[i+3] = d[31:24];
          end
        end else begin
          if (a == BASE + 4) m_out = d;
          if (a == BASE + 8 && d[0]) begin
            m_sticky = 1'b0;
            m_faddr  = '0;
          end
        end
      end
    end
  endtask

  task automatic cyc(input logic rs, input logic w, input logic r,
                     input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d);
    logic        eflt;
    logic        emis;
    logic [31:0] erd;
    @(negedge clk);
    reset     = rs;
    MemWrite  = w;
    MemRead   = r;
    funct3    = f;
    ALUResult = a;
    WriteData = d;
    #1;
    model_eval(w, r, f, a, eflt, emis, erd);
    rd_obs  = ReadData;
    mis_obs = misaligned;
    chk("rdata", ReadData, erd);
    chk("misal", {31'b0, misaligned}, {31'b0, emis});
    @(posedge clk);
    #1;
    model_commit(rs, w, f, a, d, eflt);
    chk("sticky", {31'b0, fault_sticky}, {31'b0, m_sticky});
    chk("faddr", fault_addr, m_faddr);
    chk("mmio", mmio_out, m_out);
  endtask

  task automatic idle(input logic rs);
    cyc(rs, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f;
    int          op;
    int          sel;

    repeat (3) idle(1'b1);
    chk("rst_sticky", {31'b0, fault_sticky}, 32'd0);
    chk("rst_faddr", fault_addr, 32'd0);
    chk("rst_mmio", mmio_out, 32'd0);

    for (int i = 0; i < 256; i++)
      cyc(1'b0, 1'b1, 1'b0, 3'd2, 32'(i * 4), $urandom);

    cyc(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 32'h13, 32'd0);
    chk("lb13", rd_obs, 32'hFFFF_FFDE);
    cyc(1'b0, 1'b0, 1'b1, 3'd4, 32'h13, 32'd0);
    chk("lbu13", rd_obs, 32'h0000_00DE);
    cyc(1'b0, 1'b0, 1'b1, 3'd1, 32'h12, 32'd0);
    chk("lh12", rd_obs, 32'hFFFF_DEAD);
    cyc(1'b0, 1'b0, 1'b1, 3'd5, 32'h10, 32'd0);
    chk("lhu10", rd_obs, 32'h0000_BEEF);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'd0);
    chk("lw10", rd_obs, 32'hDEAD_BEEF);

    cyc(1'b0, 1'b1, 1'b0, 3'd0, 32'h11, 32'h0000_0055);
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 32'h12, 32'h0000_1234);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'd0);
    chk("lw_merge", rd_obs, 32'h1234_55EF);

    cyc(1'b0, 1'b1, 1'b0, 3'd2, 32'h6, 32'hFFFF_FFFF);
    chk("sw6_misal", {31'b0, mis_obs}, 32'd1);
    chk("sw6_sticky", {31'b0, fault_sticky}, 32'd1);
    chk("sw6_faddr", fault_addr, 32'h6);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h4, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 32'h401, 32'd0);
    chk("keep_faddr", fault_addr, 32'h6);

    idle(1'b1);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h400, 32'd0);
    chk("oor_rd", rd_obs, 32'd0);
    chk("oor_faddr", fault_addr, 32'h400);
    idle(1'b1);
    chk("clr_sticky", {31'b0, fault_sticky}, 32'd0);
    chk("clr_faddr", fault_addr, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'd0);
    chk("retained", rd_obs, 32'h1234_55EF);

`ifdef LSU_MMIO_EN
    idle(1'b1);
    repeat (5) idle(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, BASE, 32'd0);
    chk("cnt5", rd_obs, 32'd5);
    cyc(1'b0, 1'b1, 1'b0, 3'd2, BASE + 4, 32'h0000_00A5);
    chk("mmio_a5", mmio_out, 32'h0000_00A5);
    cyc(1'b0, 1'b1, 1'b0, 3'd2, BASE, 32'd1);
    chk("cnt_st_flt", {31'b0, fault_sticky}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 3'd2, BASE + 8, 32'd1);
    chk("stat_clr", {31'b0, fault_sticky}, 32'd0);
    chk("stat_clr_a", fault_addr, 32'd0);
`else
    idle(1'b1);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, BASE, 32'd0);
    chk("nommio_rd", rd_obs, 32'd0);
    chk("nommio_flt", {31'b0, fault_sticky}, 32'd1);
    chk("nommio_out", mmio_out, 32'd0);
`endif

    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, 1023));
      else if (sel == 7) a = 32'h400 + ($urandom & 32'h000F_FFFF);
      else               a = BASE + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
      f  = 3'($urandom_range(0, 7));
      op = $urandom_range(0, 3);
      cyc(($urandom_range(0, 63) == 0), op[1], op[0], f, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
